// File: rtl/mmrv_pkg.sv
// mmrv_pkg -- shared definitions for the MMRV load/store path.
//
// Contents:
//   SZ_B, SZ_H, SZ_W, SZ_RSV : req_size encodings (byte, half, word, reserved)
//   lsu_state_t              : LSU state type with ST_IDLE/ST_READ/ST_WRITE/ST_RESP
//
// Configuration macro used by the LSU: LSU_MISALIGN_TRAP_EN
package mmrv_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE  = 2'd0;
  localparam lsu_state_t ST_READ  = 2'd1;
  localparam lsu_state_t ST_WRITE = 2'd2;
  localparam lsu_state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align -- combinational lane steering for the LSU.
//
// Lane order is big-endian inside a RAM word: the byte at offset k sits in
// bits [31-8k -: 8]; the half at offset 0 is [31:16], at offset 2 is [15:0].
//
// Ports:
//   size        in  2   access size (SZ_B / SZ_H / SZ_W)
//   is_unsigned in  1   zero-extend loads when 1, sign-extend when 0
//   offset      in  2   byte offset inside the word (already aligned for halves/words)
//   word        in  32  RAM word being read or modified
//   wdata       in  32  right-aligned store data
//   load_data   out 32  extracted and extended load result
//   store_word  out 32  word with the addressed lanes replaced by wdata
module lsu_lane_align
  import mmrv_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_bit;

  always_comb begin
    byte_sel   = word[31:24];
    half_sel   = word[31:16];
    sign_bit   = 1'b0;
    load_data  = word;
    store_word = word;

    case (offset)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[15:0] : word[31:16];

    case (size)
      SZ_B: begin
        sign_bit  = ~is_unsigned & byte_sel[7];
        load_data = {{24{sign_bit}}, byte_sel};
        case (offset)
          2'd0:    store_word = {wdata[7:0], word[23:0]};
          2'd1:    store_word = {word[31:24], wdata[7:0], word[15:0]};
          2'd2:    store_word = {word[31:16], wdata[7:0], word[7:0]};
          default: store_word = {word[31:8], wdata[7:0]};
        endcase
      end
      SZ_H: begin
        sign_bit   = ~is_unsigned & half_sel[15];
        load_data  = {{16{sign_bit}}, half_sel};
        store_word = offset[1] ? {word[31:16], wdata[15:0]}
                               : {wdata[15:0], word[15:0]};
      end
      SZ_W: begin
        load_data  = word;
        store_word = wdata;
      end
      default: begin
        load_data  = 32'h0;
        store_word = word;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu -- single-outstanding load/store unit in front of a combinational-read RAM.
//
// Loads and sub-word stores read the RAM word first (READ); stores then write
// the merged word for one cycle (WRITE); every request ends in RESP until the
// response is consumed. Reserved sizes answer with rsp_err and never touch RAM.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses answer with rsp_err, no RAM access
//   undefined : misaligned low address bits are dropped (access forced aligned)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                  request fields
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_err         load data (0 for stores/errors), error flag
//   mem_ce, mem_le, mem_addr,
//   mem_wdata, mem_rdata       RAM port (word-aligned address)
module lsu
  import mmrv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ce,
  output logic              mem_le,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;

  logic              accept;
  logic              bad_req;
  logic [ADDR_W-1:0] addr_in;
  logic [31:0]       align_word;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  assign accept = req_valid && req_ready;

  // Drop the low address bits a half/word access cannot use; with trapping
  // enabled a misaligned request becomes an error before it is ever aligned.
  always_comb begin
    addr_in = req_addr;
    if (req_size == SZ_H) addr_in[0] = 1'b0;
    if (req_size == SZ_W) addr_in[1:0] = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
    bad_req = (req_size == SZ_RSV)
            || ((req_size == SZ_H) && req_addr[0])
            || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    bad_req = (req_size == SZ_RSV);
`endif
  end

  // RAM strobes depend on state alone, so reset drops them immediately.
  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    mem_ce    = (state == ST_READ) || (state == ST_WRITE);
    mem_le    = (state == ST_WRITE);
  end

  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = store_word;
  // During READ the live RAM word feeds load extraction; during WRITE the
  // word captured in READ is merged with the store data.
  assign align_word = (state == ST_READ) ? mem_rdata : word_q;

  lsu_lane_align u_align (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .offset      (addr_q[1:0]),
    .word        (align_word),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // Main FSM with request latching and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      word_q     <= 32'h0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= addr_in;
            wdata_q    <= req_wdata;
            rsp_rdata  <= 32'h0;
            rsp_err    <= bad_req;
            if (bad_req)
              state <= ST_RESP;
            else if (req_we && (req_size == SZ_W))
              state <= ST_WRITE;
            else
              state <= ST_READ;
          end
        end
        ST_READ: begin
          word_q <= mem_rdata;
          if (we_q) begin
            state <= ST_WRITE;
          end else begin
            rsp_rdata <= load_data;
            state     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          state <= ST_RESP;
        end
        default: begin
          if (rsp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu -- self-checking bench for lsu with a behavioural RAM and a
// scoreboard of expected responses.
module tb_lsu;
  import mmrv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_ce;
  logic        mem_le;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:63];
  int          ce_cnt;
  int          le_cnt;
  int          n_vec;
  int          n_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  lsu #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_ce       (mem_ce),
    .mem_le       (mem_le),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_ce && mem_le) ram[mem_addr[7:2]] <= mem_wdata;
  end

  always @(posedge clk) begin
    if (mem_ce) ce_cnt++;
    if (mem_ce && mem_le) le_cnt++;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, req);
    end
  endtask

  // One full request/response transaction; hold > 0 keeps rsp_ready low
  // in RESP for that many cycles while a stray request is offered.
  task automatic run_req(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int hold);
    exp_t e;
    exp_t got;
    int   waitc;
    int   lat;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check32({name, "_ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = sb.pop_front();
    check32({name, "_valid"}, {31'h0, rsp_valid}, 32'h1);
    check32({name, "_lat"}, lat, got.lat);
    check32({name, "_rdata"}, rsp_rdata, got.rdata);
    check32({name, "_err"}, {31'h0, rsp_err}, {31'h0, got.err});
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = SZ_W;
      req_addr  = 32'h20;
      @(posedge clk);
      #1;
      check32({name, "_hold_valid"}, {31'h0, rsp_valid}, 32'h1);
      check32({name, "_hold_rdata"}, rsp_rdata, got.rdata);
      check32({name, "_hold_rdy"}, {31'h0, req_ready}, 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check32({name, "_done"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    check32("rst_valid", {31'h0, rsp_valid}, 32'h0);
    check32("rst_rdata", rsp_rdata, 32'h0);
    check32("rst_err", {31'h0, rsp_err}, 32'h0);
    check32("rst_ce", {31'h0, mem_ce}, 32'h0);
    check32("rst_le", {31'h0, mem_le}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check32("rst_ready", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic test_word;
    le_cnt = 0;
    run_req("sw", 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
    check32("sw_ram", ram[4], 32'hDEADBEEF);
    check32("sw_le_pulses", le_cnt, 1);
    le_cnt = 0;
    run_req("lw", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
    check32("lw_le_pulses", le_cnt, 0);
  endtask

  task automatic test_load_ext;
    run_req("pre_ld", 1'b1, SZ_W, 1'b0, 32'h10, 32'h11228344, 32'h0, 1'b0, 2, 0);
    run_req("lb", 1'b0, SZ_B, 1'b0, 32'h12, 32'h0, 32'hFFFFFF83, 1'b0, 2, 0);
    run_req("lbu", 1'b0, SZ_B, 1'b1, 32'h12, 32'h0, 32'h00000083, 1'b0, 2, 0);
    run_req("lh", 1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFF8344, 1'b0, 2, 0);
    run_req("lhu0", 1'b0, SZ_H, 1'b1, 32'h10, 32'h0, 32'h00001122, 1'b0, 2, 0);
    run_req("lb3", 1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'h00000044, 1'b0, 2, 0);
  endtask

  task automatic test_store_merge;
    run_req("pre_st", 1'b1, SZ_W, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 2, 0);
    le_cnt = 0;
    run_req("sb", 1'b1, SZ_B, 1'b0, 32'h11, 32'h000000AA, 32'h0, 1'b0, 3, 0);
    check32("sb_ram", ram[4], 32'h11AA3344);
    check32("sb_le_pulses", le_cnt, 1);
    run_req("sh", 1'b1, SZ_H, 1'b0, 32'h12, 32'h0000BEEF, 32'h0, 1'b0, 3, 0);
    check32("sh_ram", ram[4], 32'h11AABEEF);
    run_req("sb0", 1'b1, SZ_B, 1'b0, 32'h10, 32'h00000055, 32'h0, 1'b0, 3, 0);
    check32("sb0_ram", ram[4], 32'h55AABEEF);
  endtask

  task automatic test_misalign;
    run_req("pre_mis", 1'b1, SZ_W, 1'b0, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0, 2, 0);
    ce_cnt = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    run_req("lw_mis", 1'b0, SZ_W, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0);
    run_req("lh_mis", 1'b0, SZ_H, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0);
    check32("mis_ce", ce_cnt, 0);
`else
    run_req("lw_mis", 1'b0, SZ_W, 1'b0, 32'h12, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0);
    run_req("lh_mis", 1'b0, SZ_H, 1'b0, 32'h13, 32'h0, 32'hFFFFF00D, 1'b0, 2, 0);
    check32("mis_ce", ce_cnt, 2);
`endif
  endtask

  task automatic test_reserved;
    ce_cnt = 0;
    run_req("rsv_ld", 1'b0, SZ_RSV, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
    run_req("rsv_st", 1'b1, SZ_RSV, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b1, 1, 0);
    check32("rsv_ce", ce_cnt, 0);
    check32("rsv_ram", ram[4], 32'hCAFEF00D);
  endtask

  task automatic test_back_to_back;
    run_req("bp_lw", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 2, 3);
    // The stray request offered during RESP must not have been taken.
    @(posedge clk);
    #1;
    check32("bp_ignored", {31'h0, rsp_valid}, 32'h0);
    check32("bp_idle_ce", {31'h0, mem_ce}, 32'h0);
  endtask

  task automatic test_reset_write;
    int waitc;
    run_req("pre_rw", 1'b1, SZ_W, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 2, 0);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = SZ_H;
    req_unsigned = 1'b0;
    req_addr     = 32'h10;
    req_wdata    = 32'h00005566;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check32("rw_read_le", {31'h0, mem_le}, 32'h0);
    @(posedge clk);
    #1;
    check32("rw_write_le", {31'h0, mem_le}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check32("rw_rst_le", {31'h0, mem_le}, 32'h0);
    check32("rw_rst_ce", {31'h0, mem_ce}, 32'h0);
    check32("rw_rst_valid", {31'h0, rsp_valid}, 32'h0);
    check32("rw_rst_rdata", rsp_rdata, 32'h0);
    check32("rw_rst_err", {31'h0, rsp_err}, 32'h0);
    check32("rw_rst_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    check32("rw_ram", ram[4], 32'h11223344);
    @(negedge clk);
    rst_n = 1'b1;
    run_req("rw_lw", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 2, 0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    ce_cnt       = 0;
    le_cnt       = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = SZ_W;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b0;
    test_reset();
    test_word();
    test_load_ext();
    test_store_merge();
    test_misalign();
    test_reserved();
    test_back_to_back();
    test_reset_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
